serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one full-subtractor bit per clock with a registered borrow.
- It is the subtract counterpart of the ripple full-adder (two half-adder) datapath, for area-constrained ALU/branch-compare paths in the MIPS core.
- Operands are captured on a start pulse. The result is presented with a one-cycle done pulse and held stable until the next result.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one
//            full-subtractor bit per clock with a registered borrow.
//            Define SERIAL_SUB_SIGNED_OVF_EN to add the signed-overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [0:0]         c_st_idle  = 1'b0;
    localparam logic [0:0]         c_st_run   = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_work;
    logic               r_borrow;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic w_x;
    logic w_y;
    logic w_d;
    logic w_borrow_nxt;

    assign w_x          = r_a_sr[0];
    assign w_y          = r_b_sr[0];
    assign w_d          = w_x ^ w_y ^ r_borrow;
    assign w_borrow_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_work   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_borrow_nxt;
                    r_work   <= {w_d, r_work[WIDTH-1:1]};
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    // Last bit: publish the whole word at once so diff never shows partials
                    if (r_cnt == c_last_bit) begin
                        r_diff  <= {w_d, r_work[WIDTH-1:1]};
                        r_bout  <= w_borrow_nxt;
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == c_st_idle && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == c_st_run && r_cnt == c_last_bit) begin
            // w_d is the result MSB on the final edge
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == c_st_run);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (vector table, queue
//            scoreboard, hand-written multi-cycle corner sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf_s;

    int   checks;
    int   errors;
    int   n_done;
    exp_t sb_q[$];
    exp_t last_exp;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf_s)
`endif
    );

`ifndef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf_s = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                last_exp = sb_q.pop_front();
                check("diff", 32'(diff), 32'(last_exp.diff));
                check("bout", 32'(bout), 32'(last_exp.bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                check("ovf", 32'(ovf_s), 32'(last_exp.ovf));
`endif
            end
        end
    end

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.diff = v.diff;
        e.bout = v.bout;
        e.ovf  = v.ovf;
        return e;
    endfunction

    // Issue one op, check busy/done timing, then scramble a/b while busy
    task automatic run_op(input vec_t v);
        @(negedge clk);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        sb_q.push_back(mk_exp(v));
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_run", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("done_latency", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("diff_held", 32'(diff), 32'(v.diff));
        check("bout_held", 32'(bout), 32'(v.bout));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    vec_t vecs[10];
    vec_t v;
    int   cyc;
    int   snap;

    initial begin
        checks = 0;
        errors = 0;
        n_done = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        vecs[0] = '{8'd100, 8'd37, 8'd63,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,  8'hFC,  1'b1, 1'b0};
        vecs[2] = '{8'hA5,  8'hA5, 8'h00,  1'b0, 1'b0};
        vecs[3] = '{8'h00,  8'h01, 8'hFF,  1'b1, 1'b0};
        vecs[4] = '{8'd200, 8'd50, 8'd150, 1'b0, 1'b0};
        vecs[5] = '{8'h80,  8'h01, 8'h7F,  1'b0, 1'b1};
        vecs[6] = '{8'h7F,  8'hFF, 8'h80,  1'b1, 1'b1};
        vecs[7] = '{8'h10,  8'h20, 8'hF0,  1'b1, 1'b0};
        vecs[8] = '{8'hFF,  8'h00, 8'hFF,  1'b0, 1'b0};
        vecs[9] = '{8'h00,  8'hFF, 8'h01,  1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf",  32'(ovf_s), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Result must stay put through a long idle stretch
        run_op(vecs[1]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_diff", 32'(diff), 32'hFC);
            check("idle_bout", 32'(bout), 32'd1);
        end

        // Back-to-back: second start lands in the done cycle
        @(negedge clk);
        start = 1'b1;
        a = 8'hA5;
        b = 8'hA5;
        sb_q.push_back(mk_exp(vecs[2]));
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        start = 1'b1;
        a = 8'h00;
        b = 8'h01;
        sb_q.push_back(mk_exp(vecs[3]));
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_latency", 32'(cyc), 32'd9);
        @(negedge clk);

        // start held high while busy, operands changed: no second op
        snap = n_done;
        @(negedge clk);
        start = 1'b1;
        a = 8'd200;
        b = 8'd50;
        sb_q.push_back(mk_exp(vecs[4]));
        @(negedge clk);
        a = 8'd1;
        b = 8'd2;
        repeat (WIDTH - 1) @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("hold_start_dones", 32'(n_done - snap), 32'd1);
        check("hold_start_diff", 32'(diff), 32'd150);
        check("hold_start_busy", 32'(busy), 32'd0);

        // Reset sampled on the 4th RUN edge discards the op
        snap = n_done;
        @(negedge clk);
        start = 1'b1;
        a = 8'h33;
        b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", 32'(n_done - snap), 32'd0);
        v = '{8'd20, 8'd7, 8'd13, 1'b0, 1'b0};
        run_op(v);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
